// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the gpio_bank register block: the 3-bit register
// addresses seen on the j1 I/O bus, the fixed read-data width, and a helper
// that sizes the post-reset edge suppression window.
// ---------------------------------------------------------------------------
package gpio_pkg;

    // Register addresses. IN and OUT share address 0: reads return the pad
    // level, writes load the output latch.
    localparam logic [2:0] GPIO_A_IN    = 3'd0;
    localparam logic [2:0] GPIO_A_OUT   = 3'd0;
    localparam logic [2:0] GPIO_A_DIR   = 3'd1;
    localparam logic [2:0] GPIO_A_OUTRB = 3'd2;
    localparam logic [2:0] GPIO_A_SET   = 3'd3;
    localparam logic [2:0] GPIO_A_CLR   = 3'd4;
    localparam logic [2:0] GPIO_A_RISE  = 3'd5;
    localparam logic [2:0] GPIO_A_FALL  = 3'd6;
    localparam logic [2:0] GPIO_A_STAT  = 3'd7;

    // Bus data width and upper bound on the number of pins per bank.
    localparam int GPIO_MAX_WIDTH = 16;

    // Number of cycles after reset during which edge events are dropped:
    // long enough for a pin that is already high to ripple through the
    // synchroniser (and filter, when present) without looking like an edge.
    function automatic int gpio_arm_cycles(input int sync_stages, input int filt_len);
        return sync_stages + 1 + filt_len;
    endfunction

endpackage

// File: rtl/gpio_sync_filter.sv
// ---------------------------------------------------------------------------
// gpio_sync_filter
// One-bit input conditioner: a SYNC_STAGES-deep synchroniser chain followed,
// when GPIO_FILTER_EN is defined, by a level filter that only accepts a new
// level after FILT_LEN consecutive equal samples. Without GPIO_FILTER_EN the
// output is simply the last synchroniser stage and no counter is built.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous reset, active high
//   i_pin    in   raw asynchronous pad input
//   o_level  out  synchronised (and optionally filtered) level
// ---------------------------------------------------------------------------
module gpio_sync_filter #(
    parameter int SYNC_STAGES = 2
`ifdef GPIO_FILTER_EN
    ,
    parameter int FILT_LEN    = 3
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift chain that brings the asynchronous pad into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

`ifdef GPIO_FILTER_EN
    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic [3:0] r_cnt;
    logic       r_level;
    logic       w_stage;

    assign w_stage = r_sync[SYNC_STAGES-1];

    // r_cnt counts consecutive samples that disagree with the accepted
    // level; any agreeing sample restarts the count, so a glitch shorter
    // than FILT_LEN never reaches the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_stage == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= w_stage;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_level = r_level;
`else
    assign o_level = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_bank.sv
// ---------------------------------------------------------------------------
// gpio_bank
// Parametrised GPIO bank on the j1 I/O bus: output latch with set/clear,
// per-pin direction, synchronised pad input, per-pin rise/fall edge capture
// into a sticky write-1-to-clear STATUS register, and one interrupt line.
//
// Optional feature macro: GPIO_FILTER_EN adds a per-pin level filter of
// FILT_LEN samples after the synchroniser.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous reset, active high
//   wr        in   register write strobe (one cycle)
//   rd        in   register read strobe (one cycle)
//   addr      in   register select (see gpio_pkg)
//   wd        in   write data, bits >= WIDTH ignored
//   rdata     out  registered read data, valid the cycle after rd, else 0
//   pins_out  out  output latch to pad
//   pins_oe   out  1 = drive pad
//   pins_in   in   raw asynchronous pad input
//   irq       out  registered OR of STATUS
// ---------------------------------------------------------------------------
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [2:0]                addr,
    input  logic [GPIO_MAX_WIDTH-1:0] wd,
    output logic [GPIO_MAX_WIDTH-1:0] rdata,
    output logic [WIDTH-1:0]          pins_out,
    output logic [WIDTH-1:0]          pins_oe,
    input  logic [WIDTH-1:0]          pins_in,
    output logic                      irq
);

`ifdef GPIO_FILTER_EN
    localparam int ARM_CYCLES = gpio_arm_cycles(SYNC_STAGES, FILT_LEN);
`else
    localparam int ARM_CYCLES = gpio_arm_cycles(SYNC_STAGES, 0);
`endif
    // Counter is sized for the longest window of either build.
    localparam int ARM_MAX = SYNC_STAGES + 1 + FILT_LEN;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0]          r_out;
    logic [WIDTH-1:0]          r_dir;
    logic [WIDTH-1:0]          r_rise_en;
    logic [WIDTH-1:0]          r_fall_en;
    logic [WIDTH-1:0]          r_status;
    logic [WIDTH-1:0]          r_prev;
    logic [GPIO_MAX_WIDTH-1:0] r_rdata;
    logic                      r_irq;
    logic [ARM_W-1:0]          r_arm;

    logic [WIDTH-1:0]          w_sync;
    logic [WIDTH-1:0]          w_wd;
    logic [WIDTH-1:0]          w_rise;
    logic [WIDTH-1:0]          w_fall;
    logic [WIDTH-1:0]          w_event;
    logic [WIDTH-1:0]          w_w1c;
    logic [GPIO_MAX_WIDTH-1:0] w_rd_val;
    logic                      w_armed;
    logic                      w_unused_wd;

    // Bits of wd above WIDTH have no register behind them.
    assign w_wd        = wd[WIDTH-1:0];
    assign w_unused_wd = ^wd;

    // One conditioner per pin.
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        gpio_sync_filter #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_FILTER_EN
            ,
            .FILT_LEN(FILT_LEN)
`endif
        ) u_sync_filter (
            .clk    (clk),
            .reset  (reset),
            .i_pin  (pins_in[g]),
            .o_level(w_sync[g])
        );
    end

    // Edge events compare the conditioned level with last cycle's copy and
    // are masked until the arm window after reset has expired.
    assign w_armed = (r_arm == '0);
    assign w_rise  = w_sync & ~r_prev & r_rise_en;
    assign w_fall  = ~w_sync & r_prev & r_fall_en;
    assign w_event = w_armed ? (w_rise | w_fall) : '0;
    assign w_w1c   = (wr && (addr == GPIO_A_STAT)) ? w_wd : '0;

    // Read mux uses the current (pre-write) register contents, so a read
    // issued together with a write returns the old value.
    always_comb begin
        w_rd_val = '0;
        case (addr)
            GPIO_A_IN:    w_rd_val[WIDTH-1:0] = w_sync;
            GPIO_A_DIR:   w_rd_val[WIDTH-1:0] = r_dir;
            GPIO_A_OUTRB: w_rd_val[WIDTH-1:0] = r_out;
            GPIO_A_RISE:  w_rd_val[WIDTH-1:0] = r_rise_en;
            GPIO_A_FALL:  w_rd_val[WIDTH-1:0] = r_fall_en;
            GPIO_A_STAT:  w_rd_val[WIDTH-1:0] = r_status;
            default:      w_rd_val = '0;
        endcase
    end

    // Arm counter reloads on reset and counts down to zero once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arm <= ARM_W'(ARM_CYCLES);
        end else if (r_arm != '0) begin
            r_arm <= r_arm - ARM_W'(1);
        end
    end

    // Register file, sticky status, edge history, irq and read data. A new
    // event is OR'd in after the w1c mask so it survives a clear in the
    // same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_prev    <= '0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (wr) begin
                case (addr)
                    GPIO_A_OUT:  r_out     <= w_wd;
                    GPIO_A_DIR:  r_dir     <= w_wd;
                    GPIO_A_SET:  r_out     <= r_out | w_wd;
                    GPIO_A_CLR:  r_out     <= r_out & ~w_wd;
                    GPIO_A_RISE: r_rise_en <= w_wd;
                    GPIO_A_FALL: r_fall_en <= w_wd;
                    default:     ;
                endcase
            end
            r_status <= (r_status & ~w_w1c) | w_event;
            r_prev   <= w_sync;
            r_irq    <= |r_status;
            r_rdata  <= rd ? w_rd_val : '0;
        end
    end

    assign pins_out = r_out;
    assign pins_oe  = r_dir;
    assign rdata    = r_rdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// ---------------------------------------------------------------------------
// tb_gpio_bank
// Self-checking bench for gpio_bank. A WIDTH=8 instance is checked against a
// behavioural model (delay queue for the synchroniser, sample history for the
// filter, plain register variables for the map); WIDTH=5 and WIDTH=16
// instances share the bus to check read-data masking.
// ---------------------------------------------------------------------------
module tb_gpio_bank;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int FL = 3;
`ifdef GPIO_FILTER_EN
    localparam int ARM = SS + 1 + FL;
    localparam int LAT = SS + FL + 1;
`else
    localparam int ARM = SS + 1;
    localparam int LAT = SS + 1;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [2:0]  addr  = 3'd0;
    logic [15:0] wd    = 16'h0;
    logic [7:0]  pinsIn = 8'h00;

    logic [15:0] rdata, rdata5, rdata16;
    logic [7:0]  pinsOut, pinsOe;
    logic [4:0]  pinsOut5, pinsOe5;
    logic [15:0] pinsOut16, pinsOe16;
    logic        irq, irq5, irq16;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wd(wd),
        .rdata(rdata), .pins_out(pinsOut), .pins_oe(pinsOe), .pins_in(pinsIn), .irq(irq));

    gpio_bank #(.WIDTH(5), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut5 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wd(wd),
        .rdata(rdata5), .pins_out(pinsOut5), .pins_oe(pinsOe5), .pins_in(5'b0), .irq(irq5));

    gpio_bank #(.WIDTH(16), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut16 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wd(wd),
        .rdata(rdata16), .pins_out(pinsOut16), .pins_oe(pinsOe16), .pins_in(16'h0), .irq(irq16));

    // Reference model state: values visible after the most recent edge.
    logic [7:0]  mOut, mDir, mRise, mFall, mStat, mSync, mPrev;
    logic [15:0] mRdata;
    logic        mIrq;
    int          mEdges;
    logic [7:0]  pinHist[$];
    logic [7:0]  rawHist[$];

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        logic [7:0]  ev, d, raw;
        logic [15:0] rv;
        logic        allNew;
        if (reset) begin
            mOut = 8'h0; mDir = 8'h0; mRise = 8'h0; mFall = 8'h0; mStat = 8'h0;
            mSync = 8'h0; mPrev = 8'h0; mRdata = 16'h0; mIrq = 1'b0; mEdges = 0;
            pinHist.delete();
            rawHist.delete();
            return;
        end
        d  = wd[7:0];
        ev = (mEdges >= ARM) ? ((mSync & ~mPrev & mRise) | (~mSync & mPrev & mFall)) : 8'h00;
        mEdges++;
        rv = 16'h0;
        if (rd) begin
            case (addr)
                3'd0: rv[7:0] = mSync;
                3'd1: rv[7:0] = mDir;
                3'd2: rv[7:0] = mOut;
                3'd5: rv[7:0] = mRise;
                3'd6: rv[7:0] = mFall;
                3'd7: rv[7:0] = mStat;
                default: rv = 16'h0;
            endcase
        end
        mRdata = rv;
        mIrq   = |mStat;
        if (wr && addr == 3'd7) mStat = mStat & ~d;
        mStat = mStat | ev;
        if (wr) begin
            case (addr)
                3'd0: mOut = d;
                3'd1: mDir = d;
                3'd3: mOut = mOut | d;
                3'd4: mOut = mOut & ~d;
                3'd5: mRise = d;
                3'd6: mFall = d;
                default: ;
            endcase
        end
        pinHist.push_back(pinsIn);
        if (pinHist.size() > 32) void'(pinHist.pop_front());
        raw   = (pinHist.size() >= SS) ? pinHist[pinHist.size() - SS] : 8'h00;
        mPrev = mSync;
`ifdef GPIO_FILTER_EN
        for (int b = 0; b < 8; b++) begin
            if (rawHist.size() >= FL) begin
                allNew = 1'b1;
                for (int k = 1; k <= FL; k++)
                    if (rawHist[rawHist.size() - k][b] == mPrev[b]) allNew = 1'b0;
                if (allNew) mSync[b] = ~mPrev[b];
            end
        end
        rawHist.push_back(raw);
        if (rawHist.size() > 32) void'(rawHist.pop_front());
`else
        allNew = 1'b0;
        mSync  = raw | {8{allNew}};
`endif
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [15:0] d);
        wr = 1'b1; addr = a; wd = d;
        step();
        wr = 1'b0;
    endtask

    task automatic busRead(input logic [2:0] a);
        rd = 1'b1; addr = a;
        step();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        pinsIn = 8'hFF;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        testCount++; if (pinsOut !== 8'h00) begin failCount++; $display("[TB] FAIL reset_pins_out: got %h expected 00", pinsOut); end
        testCount++; if (pinsOe !== 8'h00) begin failCount++; $display("[TB] FAIL reset_pins_oe: got %h expected 00", pinsOe); end
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata); end
        testCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        busWrite(3'd5, 16'h00FF);
        for (int i = 0; i < ARM + 4; i++) begin
            step();
            testCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL arm_irq cycle %0d: got %b expected 0", i, irq); end
        end
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0 || rdata !== mRdata) begin failCount++; $display("[TB] FAIL arm_status: got %h expected 0000", rdata); end
    endtask

    task automatic test_out_dir();
        busWrite(3'd0, 16'h00A5);
        testCount++; if (pinsOut !== 8'hA5) begin failCount++; $display("[TB] FAIL out_write: got %h expected a5", pinsOut); end
        busWrite(3'd1, 16'h000F);
        busWrite(3'd3, 16'h0010);
        busWrite(3'd4, 16'h0001);
        testCount++; if (pinsOut !== 8'hB4 || pinsOut !== mOut) begin failCount++; $display("[TB] FAIL set_clr_out: got %h expected b4", pinsOut); end
        testCount++; if (pinsOe !== 8'h0F || pinsOe !== mDir) begin failCount++; $display("[TB] FAIL dir_oe: got %h expected 0f", pinsOe); end
        busRead(3'd2);
        testCount++; if (rdata !== 16'h00B4) begin failCount++; $display("[TB] FAIL outrb_read: got %h expected 00b4", rdata); end
        step();
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL rdata_hold: got %h expected 0000", rdata); end
        busRead(3'd3);
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL wo_read: got %h expected 0000", rdata); end
    endtask

    task automatic test_rise_irq();
        logic exp;
        busWrite(3'd5, 16'h0001);
        pinsIn = 8'h00;
        repeat (LAT + 3) step();
        busWrite(3'd7, 16'h00FF);
        step();
        pinsIn = 8'h01;
        for (int i = 1; i <= LAT + 2; i++) begin
            rd = 1'b1; addr = 3'd7;
            step();
            exp = (i >= LAT + 1);
            testCount++; if (rdata !== {15'h0, exp} || rdata !== mRdata) begin failCount++; $display("[TB] FAIL rise_status cycle %0d: got %h expected %h", i, rdata, {15'h0, exp}); end
            testCount++; if (irq !== exp) begin failCount++; $display("[TB] FAIL rise_irq cycle %0d: got %b expected %b", i, irq, exp); end
        end
        rd = 1'b0;
        busWrite(3'd7, 16'h0001);
        step();
        testCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL w1c_irq: got %b expected 0", irq); end
    endtask

    task automatic test_fall_w1c();
        busWrite(3'd6, 16'h0008);
        pinsIn = 8'h09;
        repeat (LAT + 2) step();
        pinsIn = 8'h01;
        repeat (LAT + 2) step();
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0008) begin failCount++; $display("[TB] FAIL fall_status: got %h expected 0008", rdata); end
        pinsIn = 8'h09;
        repeat (LAT + 2) step();
        pinsIn = 8'h01;
        repeat (LAT - 1) step();
        busWrite(3'd7, 16'h0008);
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0008 || rdata !== mRdata) begin failCount++; $display("[TB] FAIL event_beats_w1c: got %h expected 0008", rdata); end
        busWrite(3'd7, 16'h0008);
        step();
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL fall_cleared: got %h expected 0000", rdata); end
        testCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL fall_irq_clear: got %b expected 0", irq); end
    endtask

    task automatic test_width();
        busWrite(3'd1, 16'hFFFF);
        testCount++; if (pinsOe !== 8'hFF) begin failCount++; $display("[TB] FAIL dir_all_oe: got %h expected ff", pinsOe); end
        busRead(3'd1);
        testCount++; if (rdata !== 16'h00FF) begin failCount++; $display("[TB] FAIL dir_read_w8: got %h expected 00ff", rdata); end
        testCount++; if (rdata5 !== 16'h001F) begin failCount++; $display("[TB] FAIL dir_read_w5: got %h expected 001f", rdata5); end
        testCount++; if (rdata16 !== 16'hFFFF) begin failCount++; $display("[TB] FAIL dir_read_w16: got %h expected ffff", rdata16); end
    endtask

`ifdef GPIO_FILTER_EN
    task automatic test_filter();
        logic seenHigh;
        busWrite(3'd5, 16'h0002);
        busWrite(3'd7, 16'h00FF);
        pinsIn = 8'h03;
        repeat (2) step();
        pinsIn = 8'h01;
        for (int i = 0; i < SS + FL + 3; i++) begin
            rd = 1'b1; addr = 3'd0;
            step();
            testCount++; if (rdata[1] !== 1'b0 || rdata !== mRdata) begin failCount++; $display("[TB] FAIL glitch_in cycle %0d: got %h expected %h", i, rdata, mRdata); end
        end
        rd = 1'b0;
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL glitch_status: got %h expected 0000", rdata); end
        pinsIn = 8'h03;
        seenHigh = 1'b0;
        for (int i = 0; i < SS + FL + 6; i++) begin
            if (i == 4) pinsIn = 8'h01;
            rd = 1'b1; addr = 3'd0;
            step();
            if (rdata[1] === 1'b1) seenHigh = 1'b1;
        end
        rd = 1'b0;
        testCount++; if (seenHigh !== 1'b1) begin failCount++; $display("[TB] FAIL filter_accept: got %b expected 1", seenHigh); end
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0002 || rdata !== mRdata) begin failCount++; $display("[TB] FAIL filter_rise: got %h expected 0002", rdata); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr   = ($urandom_range(0, 2) == 0);
            rd   = 1'($urandom_range(0, 1));
            addr = 3'($urandom_range(0, 7));
            wd   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pinsIn = 8'($urandom);
            step();
            testCount++; if (pinsOut !== mOut) begin failCount++; $display("[TB] FAIL rand_out cycle %0d: got %h expected %h", i, pinsOut, mOut); end
            testCount++; if (pinsOe !== mDir) begin failCount++; $display("[TB] FAIL rand_oe cycle %0d: got %h expected %h", i, pinsOe, mDir); end
            testCount++; if (rdata !== mRdata) begin failCount++; $display("[TB] FAIL rand_rdata cycle %0d: got %h expected %h", i, rdata, mRdata); end
            testCount++; if (irq !== mIrq) begin failCount++; $display("[TB] FAIL rand_irq cycle %0d: got %b expected %b", i, irq, mIrq); end
        end
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        pinsIn = 8'hFF;
        busWrite(3'd1, 16'h0033);
        rd = 1'b1; addr = 3'd1;
        step();
        testCount++; if (rdata !== 16'h0033) begin failCount++; $display("[TB] FAIL pre_reset_read: got %h expected 0033", rdata); end
        reset = 1'b1;
        step();
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL midreset_rdata: got %h expected 0000", rdata); end
        testCount++; if (pinsOe !== 8'h00) begin failCount++; $display("[TB] FAIL midreset_oe: got %h expected 00", pinsOe); end
        testCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        rd    = 1'b0;
        busWrite(3'd5, 16'h00FF);
        for (int i = 0; i < ARM + 4; i++) begin
            step();
            testCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL rearm_irq cycle %0d: got %b expected 0", i, irq); end
        end
        busRead(3'd7);
        testCount++; if (rdata !== 16'h0) begin failCount++; $display("[TB] FAIL rearm_status: got %h expected 0000", rdata); end
    endtask

    initial begin
        test_reset();
        test_out_dir();
        test_rise_irq();
        test_fall_w1c();
        test_width();
`ifdef GPIO_FILTER_EN
        test_filter();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
